// File: rtl/eda_fifo_reader_pkg.sv
// Shared definitions for the neighbour-FIFO drain reader: widths, FSM states and
// direction codes.
package eda_fifo_reader_pkg;

  localparam int unsigned CFG_ADDR_WIDTH = 12;
  localparam int unsigned CFG_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StPop,
    StWait,
    StCapture,
    StOut
  } state_e;

  // Direction code c maps to flag/read_en bit (7 - c).
  localparam logic [2:0] DIR_UPLEFT    = 3'd0;
  localparam logic [2:0] DIR_UP        = 3'd1;
  localparam logic [2:0] DIR_UPRIGHT   = 3'd2;
  localparam logic [2:0] DIR_LEFT      = 3'd3;
  localparam logic [2:0] DIR_RIGHT     = 3'd4;
  localparam logic [2:0] DIR_DOWNLEFT  = 3'd5;
  localparam logic [2:0] DIR_DOWN      = 3'd6;
  localparam logic [2:0] DIR_DOWNRIGHT = 3'd7;

endpackage

// File: rtl/eda_fifo_reader_if.sv
// FIFO-side and address-stream signals of the drain reader; master is the reader.
interface eda_fifo_reader_if
  import eda_fifo_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CFG_ADDR_WIDTH
);
  logic [7:0]              fifo_empty;
  logic [ADDR_WIDTH*8-1:0] data_out;
  logic [7:0]              read_en;
  logic                    addr_valid;
  logic                    addr_ready;
  logic [ADDR_WIDTH-1:0]   addr_out;
  logic [2:0]              dir_out;

  modport master (
    input  fifo_empty, data_out, addr_ready,
    output read_en, addr_valid, addr_out, dir_out
  );

  modport slave (
    output fifo_empty, data_out, addr_ready,
    input  read_en, addr_valid, addr_out, dir_out
  );
endinterface

// File: rtl/eda_fifo_reader_rr_pick8.sv
// Combinational round-robin search: first set request bit at or after i_start,
// wrapping modulo 8.
module eda_rr_pick8 (
  input  logic [7:0] i_req,
  input  logic [2:0] i_start,
  output logic       o_found,
  output logic [2:0] o_code
);

  logic [2:0] w_idx;

  always_comb begin
    o_found = 1'b0;
    o_code  = 3'd0;
    w_idx   = i_start;
    for (int i = 0; i < 8; i++) begin
      w_idx = i_start + 3'(i);
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_code  = w_idx;
      end
    end
  end

endmodule

// File: rtl/eda_fifo_reader.sv
// Drains eight neighbour FIFOs in round-robin order, one registered pop at a time,
// presenting each entry on a valid/ready address stream.
module eda_fifo_reader
  import eda_fifo_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = CFG_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  eda_fifo_reader_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pop_count
);

  state_e                r_state;
  logic [2:0]            r_sel;
  logic [2:0]            r_last_sel;
  logic [7:0]            r_read_en;
  logic                  r_addr_valid;
  logic [ADDR_WIDTH-1:0] r_addr_out;
  logic [2:0]            r_dir_out;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_pop_count;

  logic [7:0]            w_req;
  logic [2:0]            w_start;
  logic                  w_found;
  logic [2:0]            w_code;
  logic [ADDR_WIDTH-1:0] w_slice;

  // Requests indexed by direction code rather than flag bit.
  always_comb begin
    w_req = 8'h00;
    for (int c = 0; c < 8; c++) begin
      w_req[c] = ~bus.fifo_empty[7-c];
    end
  end

  always_comb begin
    w_slice = '0;
    for (int c = 0; c < 8; c++) begin
      if (r_sel == 3'(c)) begin
        w_slice = bus.data_out[(7-c)*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign w_start = r_last_sel + 3'd1;

  eda_rr_pick8 u_pick (
    .i_req   (w_req),
    .i_start (w_start),
    .o_found (w_found),
    .o_code  (w_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_sel        <= 3'd0;
      r_last_sel   <= DIR_DOWNRIGHT;
      r_read_en    <= 8'h00;
      r_addr_valid <= 1'b0;
      r_addr_out   <= '0;
      r_dir_out    <= 3'd0;
      r_done       <= 1'b0;
      r_pop_count  <= '0;
    end else begin
      r_read_en <= 8'h00;
      r_done    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StSelect;
            r_pop_count <= '0;
          end
        end
        StSelect: begin
          if (!w_found) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end else begin
            r_sel     <= w_code;
            r_read_en <= 8'h80 >> w_code;
            r_state   <= StPop;
          end
        end
        StPop:  r_state <= StWait;
        StWait: r_state <= StCapture;
        StCapture: begin
          r_addr_out   <= w_slice;
          r_dir_out    <= r_sel;
          r_addr_valid <= 1'b1;
          r_last_sel   <= r_sel;
          r_state      <= StOut;
        end
        StOut: begin
          if (bus.addr_ready) begin
            r_addr_valid <= 1'b0;
            r_pop_count  <= r_pop_count + CNT_WIDTH'(1);
            r_state      <= StSelect;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.read_en    = r_read_en;
  assign bus.addr_valid = r_addr_valid;
  assign bus.addr_out   = r_addr_out;
  assign bus.dir_out    = r_dir_out;
  assign busy           = (r_state != StIdle);
  assign done           = r_done;
  assign pop_count      = r_pop_count;

endmodule

// File: tb/tb_eda_fifo_reader.sv
// Randomized bench for eda_fifo_reader with behavioural FIFOs and a round-robin
// transaction-level predictor.
module tb_eda_fifo_reader;
  import eda_fifo_reader_pkg::*;

  localparam int unsigned AW = CFG_ADDR_WIDTH;
  localparam int unsigned CW = CFG_CNT_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [CW-1:0] pop_count;

  eda_fifo_reader_if #(.ADDR_WIDTH(AW)) bus ();

  eda_fifo_reader #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pop_count (pop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // fq: the FIFOs seen by the DUT; rq: the predictor's view. Both indexed by code.
  logic [AW-1:0] fq[8][$];
  logic [AW-1:0] rq[8][$];
  logic [AW-1:0] hd[8];
  int            exp_last;
  int            exp_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < 8; c++) begin
      bus.fifo_empty[7-c]          = (fq[c].size() == 0);
      bus.data_out[(7-c)*AW +: AW] = hd[c];
    end
  endtask

  // Registered-read FIFO behaviour: a pop strobe loads the head register.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      if (bus.read_en[7-c] && fq[c].size() > 0) hd[c] = fq[c].pop_front();
    end
    refresh();
  endtask

  task automatic push(input int c, input logic [AW-1:0] v);
    fq[c].push_back(v);
    rq[c].push_back(v);
    refresh();
  endtask

  function automatic int rr_ref(input int from);
    for (int k = 0; k < 8; k++) begin
      if (rq[(from + k) % 8].size() != 0) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset          = 1'b1;
    start          = 1'b0;
    bus.addr_ready = 1'b0;
    tick();
    reset    = 1'b0;
    exp_last = 7;
    exp_cnt  = 0;
    check_val("rst_valid", 32'(bus.addr_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_read_en", 32'(bus.read_en), 0);
    check_val("rst_cnt", 32'(pop_count), 0);
    check_val("rst_addr", 32'(bus.addr_out), 0);
    check_val("rst_dir", 32'(bus.dir_out), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start   = 1'b0;
    exp_cnt = 0;
    check_val("start_busy", 32'(busy), 1);
    check_val("start_cnt", 32'(pop_count), 0);
  endtask

  task automatic serve_one(input int stall, input bit refill);
    int            code;
    int            n;
    logic [AW-1:0] ev;
    logic [7:0]    exp_re;
    code   = rr_ref((exp_last + 1) % 8);
    ev     = rq[code].pop_front();
    exp_re = 8'h80 >> code;
    n = 0;
    while (bus.read_en == 8'h00 && n < 8) begin
      tick();
      n++;
    end
    check_val("pop_wait", n, 1);
    check_val("read_en", 32'(bus.read_en), 32'(exp_re));
    n = 0;
    while (!bus.addr_valid && n < 8) begin
      tick();
      n++;
    end
    check_val("valid_lat", n, 3);
    check_val("read_en_off", 32'(bus.read_en), 0);
    check_val("addr", 32'(bus.addr_out), 32'(ev));
    check_val("dir", 32'(bus.dir_out), code);
    for (int s = 0; s < stall; s++) begin
      if (refill && s == 0) push($urandom_range(0, 7), AW'($urandom));
      tick();
      check_val("hold_valid", 32'(bus.addr_valid), 1);
      check_val("hold_addr", 32'(bus.addr_out), 32'(ev));
      check_val("hold_dir", 32'(bus.dir_out), code);
      check_val("hold_read_en", 32'(bus.read_en), 0);
      check_val("hold_cnt", 32'(pop_count), exp_cnt);
    end
    bus.addr_ready = 1'b1;
    tick();
    bus.addr_ready = 1'b0;
    exp_cnt++;
    exp_last = code;
    check_val("acc_valid", 32'(bus.addr_valid), 0);
    check_val("acc_cnt", 32'(pop_count), exp_cnt);
  endtask

  task automatic finish_drain();
    int n;
    n = 0;
    while (!done && n < 4) begin
      tick();
      n++;
    end
    check_val("done_wait", n, 1);
    check_val("done", 32'(done), 1);
    check_val("done_read_en", 32'(bus.read_en), 0);
    check_val("done_cnt", 32'(pop_count), exp_cnt);
    tick();
    check_val("done_pulse", 32'(done), 0);
    check_val("idle_busy", 32'(busy), 0);
  endtask

  task automatic drain(input int max_stall, input int refill_pct);
    int served;
    served = 0;
    pulse_start();
    while (rr_ref(0) >= 0 && served < 64) begin
      serve_one($urandom_range(0, max_stall), ($urandom_range(0, 99) < refill_pct));
      served++;
    end
    finish_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b1;
    start          = 1'b0;
    bus.addr_ready = 1'b0;
    bus.fifo_empty = 8'hFF;
    bus.data_out   = '0;
    for (int c = 0; c < 8; c++) hd[c] = '0;
    refresh();
    do_reset();

    // Single "up" entry right after reset.
    push(1, 12'h0A5);
    drain(0, 0);
    check_val("single_cnt", 32'(pop_count), 1);

    // One entry in every FIFO drains in code order 0..7.
    do_reset();
    for (int c = 0; c < 8; c++) push(c, AW'($urandom));
    drain(0, 0);
    check_val("all8_cnt", 32'(pop_count), 8);

    // Round-robin resumes after last_sel: left served, then right-side search hits 7.
    push(3, AW'($urandom));
    drain(0, 0);
    push(7, AW'($urandom));
    push(3, AW'($urandom));
    drain(0, 0);

    // Long back-pressure.
    push(2, AW'($urandom));
    pulse_start();
    serve_one(10, 0);
    finish_drain();

    // Reset while an entry is held in OUT.
    push(0, AW'($urandom));
    push(5, AW'($urandom));
    pulse_start();
    n = 0;
    while (!bus.addr_valid && n < 8) begin
      tick();
      n++;
    end
    check_val("pre_rst_valid", 32'(bus.addr_valid), 1);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      fq[c].delete();
      rq[c].delete();
    end
    refresh();
    pulse_start();
    check_val("empty_read_en0", 32'(bus.read_en), 0);
    tick();
    check_val("empty_done", 32'(done), 1);
    check_val("empty_read_en1", 32'(bus.read_en), 0);
    tick();
    check_val("empty_done_off", 32'(done), 0);

    // Randomized drains with stalls and mid-drain refills.
    for (int t = 0; t < 20; t++) begin
      int np;
      np = $urandom_range(0, 6);
      for (int k = 0; k < np; k++) push($urandom_range(0, 7), AW'($urandom));
      drain(3, 25);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
